rr_reg_arbiter: RTL and testbench

RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

---
 rtl/rr_reg_arbiter_if.sv | 26 ++
 rtl/rr_reg_arbiter.sv | 91 +++++++++
 tb/tb_rr_reg_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_reg_arbiter_if.sv
// Write-request / read-port bundle for rr_reg_arbiter.
// master drives requests and read address; slave returns grants and data.
interface rr_reg_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
);
    logic                 clr;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   wr_addr;
    logic [NREQ*DW-1:0]   wr_data;
    logic [NREQ-1:0]      gnt;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_data;
    logic                 busy;

    modport master (
        output clr, req, wr_addr, wr_data, rd_addr,
        input  gnt, rd_data, busy
    );

    modport slave (
        input  clr, req, wr_addr, wr_data, rd_addr,
        output gnt, rd_data, busy
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Register bank written by NREQ requesters through a round-robin arbiter.
// Registered one-hot grant, busy flag and read-before-write read port.
module rr_reg_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input logic            clk,
    input logic            n_rst,
    rr_reg_arbiter_if.slave bus
);
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]   bank [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    logic [NREQ-1:0] eff;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] gnt_next;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [DW-1:0]   rd_q;
    logic            busy_q;
    int              idx;

    // A requester granted this cycle is masked so it cannot win twice
    assign eff = bus.req & ~gnt_q;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_valid && eff[idx[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                w_addr = bus.wr_addr[i*AW +: AW];
                w_data = bus.wr_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        gnt_next = NREQ'(1) << win_idx;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int e = 0; e < DEPTH; e++) bank[e] <= '0;
            rd_q   <= '0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            ptr    <= '0;
        end else begin
            rd_q <= bank[bus.rd_addr];
            if (bus.clr) begin
                for (int e = 0; e < DEPTH; e++) bank[e] <= '0;
                gnt_q  <= '0;
                busy_q <= 1'b0;
                ptr    <= '0;
            end else if (win_valid) begin
                bank[w_addr] <= w_data;
                gnt_q        <= gnt_next;
                busy_q       <= 1'b1;
                ptr          <= ptr_next;
            end else begin
                gnt_q  <= '0;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed and random checks of rr_reg_arbiter against a behavioural model.
// Model arbitrates by scanning requesters in rotated order from a pointer.
module tb_rr_reg_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int D  = 1 << AW;

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;

    logic [DW-1:0] m_bank [D];
    logic [N-1:0]  m_gnt;
    logic          m_busy;
    logic [DW-1:0] m_rd;
    int            m_ptr;

    rr_reg_arbiter_if #(.NREQ(N), .DW(DW), .AW(AW)) bus ();

    rr_reg_arbiter #(.NREQ(N), .DW(DW), .AW(AW)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int e = 0; e < D; e++) m_bank[e] = '0;
        m_gnt  = '0;
        m_busy = 1'b0;
        m_rd   = '0;
        m_ptr  = 0;
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] rd_new;
        logic [N-1:0]  pend;
        int            order [$];
        int            w;
        rd_new = m_bank[bus.rd_addr];
        if (bus.clr) begin
            for (int e = 0; e < D; e++) m_bank[e] = '0;
            m_gnt  = '0;
            m_busy = 1'b0;
            m_ptr  = 0;
        end else begin
            pend = bus.req & ~m_gnt;
            for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
            w = -1;
            foreach (order[k]) if (w < 0 && pend[order[k]]) w = order[k];
            if (w >= 0) begin
                m_bank[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*DW +: DW];
                m_gnt  = N'(1) << w;
                m_busy = 1'b1;
                m_ptr  = (w + 1) % N;
            end else begin
                m_gnt  = '0;
                m_busy = 1'b0;
            end
        end
        m_rd = rd_new;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.wr_addr[i*AW +: AW] = a;
        bus.wr_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        bus.clr = 0; bus.req = '0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.rd_addr = '0;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=0000", bus.gnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd got=%h exp=00", bus.rd_data);
        end
        #10 n_rst = 1'b1;
    endtask

    task automatic test_single_write();
        set_req(0, 3'd3, 8'hA5);
        bus.req = 4'b0001;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gnt got=%b/%b exp=0001/1",
                     bus.gnt, bus.busy);
        end
        bus.req = '0;
        bus.rd_addr = 3'd3;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got=%b/%b exp=0000/0",
                     bus.gnt, bus.busy);
        end
        checks++;
        if (bus.rd_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_rd got=%h exp=a5", bus.rd_data);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, AW'(4 + i), DW'(8'h30 + i));
        bus.req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (bus.gnt !== exp_seq[c]) begin
                failures++;
                $display("FAIL fair_gnt%0d got=%b exp=%b",
                         c, bus.gnt, exp_seq[c]);
            end
        end
        bus.req = '0;
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = AW'(4 + i);
            cycle();
            checks++;
            if (bus.rd_data !== DW'(8'h30 + i)) begin
                failures++;
                $display("FAIL fair_rd%0d got=%h exp=%h",
                         i, bus.rd_data, DW'(8'h30 + i));
            end
        end
    endtask

    task automatic test_wrap();
        bus.req = 4'b1000;
        cycle();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_g3 got=%b exp=1000", bus.gnt);
        end
        bus.req = 4'b1001;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_g0 got=%b exp=0001", bus.gnt);
        end
        cycle();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_g3b got=%b exp=1000", bus.gnt);
        end
        bus.req = '0;
        cycle();
    endtask

    task automatic test_collision();
        set_req(1, 3'd5, 8'h11);
        bus.req = 4'b0010;
        cycle();
        bus.req = '0;
        cycle();
        set_req(1, 3'd5, 8'h22);
        bus.req = 4'b0010;
        bus.rd_addr = 3'd5;
        cycle();
        checks++;
        if (bus.rd_data !== 8'h11 || bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL coll_pre got=%h/%b exp=11/0010",
                     bus.rd_data, bus.gnt);
        end
        bus.req = '0;
        cycle();
        checks++;
        if (bus.rd_data !== 8'h22) begin
            failures++;
            $display("FAIL coll_post got=%h exp=22", bus.rd_data);
        end
    endtask

    task automatic test_clear();
        set_req(2, 3'd6, 8'h77);
        bus.req = 4'b0100;
        bus.clr = 1'b1;
        bus.rd_addr = 3'd5;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_gnt got=%b/%b exp=0000/0",
                     bus.gnt, bus.busy);
        end
        checks++;
        if (bus.rd_data !== 8'h22) begin
            failures++;
            $display("FAIL clr_rd got=%h exp=22", bus.rd_data);
        end
        bus.clr = 1'b0;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL clr_rearb got=%b exp=0100", bus.gnt);
        end
        bus.req = '0;
        for (int a = 0; a < D; a++) begin
            bus.rd_addr = AW'(a);
            cycle();
            checks++;
            if (bus.rd_data !== ((a == 6) ? 8'h77 : 8'h00)) begin
                failures++;
                $display("FAIL clr_entry%0d got=%h exp=%h", a,
                         bus.rd_data, (a == 6) ? 8'h77 : 8'h00);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.req = 4'b0010;
        bus.rd_addr = 3'd6;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL ar_pre got=%b exp=0010", bus.gnt);
        end
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 ||
            bus.rd_data !== 8'h00) begin
            failures++;
            $display("FAIL ar_clear got=%b/%b/%h exp=0000/0/00",
                     bus.gnt, bus.busy, bus.rd_data);
        end
        #1 n_rst = 1'b1;
        bus.req = 4'b1111;
        cycle();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL ar_prio got=%b exp=0001", bus.gnt);
        end
        bus.req = '0;
        cycle();
        checks++;
        if (bus.rd_data !== 8'h00) begin
            failures++;
            $display("FAIL ar_entry got=%h exp=00", bus.rd_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.req     = N'($urandom);
            bus.wr_addr = (N*AW)'($urandom);
            bus.wr_data = (N*DW)'($urandom);
            bus.rd_addr = AW'($urandom);
            bus.clr     = ($urandom_range(0, 15) == 0);
            cycle();
            checks++;
            if (bus.gnt !== m_gnt || bus.busy !== m_busy ||
                bus.rd_data !== m_rd) begin
                failures++;
                $display("FAIL rand%0d got=%b/%b/%h exp=%b/%b/%h", c,
                         bus.gnt, bus.busy, bus.rd_data,
                         m_gnt, m_busy, m_rd);
            end
        end
        bus.req = '0;
        bus.clr = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_fairness();
        test_wrap();
        test_collision();
        test_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
